// File: rtl/alu_exec_16_if.sv
// alu_exec_16_if: instruction handshake, register-file bus and status of alu_exec_16
interface alu_exec_16_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [3:0]  dst;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [15:0] imm;
    logic [3:0]  AA;
    logic [3:0]  BA;
    logic [15:0] A;
    logic [15:0] B;
    logic        write;
    logic [3:0]  DA;
    logic [15:0] D;
    logic [3:0]  flags;
    logic        done;
    logic        illegal;
    modport master (
        output in_valid, op, dst, src_a, src_b, imm, A, B,
        input  in_ready, AA, BA, write, DA, D, flags, done, illegal
    );
    modport slave (
        input  in_valid, op, dst, src_a, src_b, imm, A, B,
        output in_ready, AA, BA, write, DA, D, flags, done, illegal
    );
endinterface

// File: rtl/alu_exec_16.sv
// alu_exec_16: multi-cycle execute stage (IDLE/READ/EXEC/MUL/WB) in front of a 16x16 register file
// Define ALU_MUL_EN to build the shift-add multiplier for opcode D; otherwise D retires as illegal.
module alu_exec_16 #(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 16
) (
    input logic          clock,
    input logic          reset,
    alu_exec_16_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0, READ = 3'd1, EXEC = 3'd2, WB = 3'd3;
`ifdef ALU_MUL_EN
    localparam logic [2:0] MUL = 3'd4;
    localparam int CW = $clog2(MUL_CYCLES + 1);
`endif
    // Unsupported geometries never accept an instruction.
    localparam logic CFG_OK = (WIDTH == 16) && (MUL_CYCLES == WIDTH);
    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
                           OP_XOR = 4'h4, OP_NOT = 4'h5, OP_MOV = 4'h6, OP_SHL = 4'h7,
                           OP_SHR = 4'h8, OP_SRA = 4'h9, OP_LDI = 4'hA, OP_INC = 4'hB,
                           OP_DEC = 4'hC, OP_MUL = 4'hD, OP_CMP = 4'hE, OP_NOP = 4'hF;

    logic [2:0]       state;
    logic [3:0]       op_q, dst_q, src_a_q, src_b_q, flags_q;
    logic [WIDTH-1:0] imm_q, result, y, r;
    logic [WIDTH:0]   sum, shl, shr, sra;
    logic             ready, cin, c, v, upd, bad;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mcand, mplier, acc, acc_n;
    logic [CW-1:0]    cnt;
    assign acc_n = acc + (mplier[0] ? mcand : '0);
    assign bad   = 1'b0;
`else
    assign bad   = (op_q == OP_MUL);
`endif

    assign ready       = CFG_OK && (state == IDLE);
    assign bus.in_ready = ready;
    assign bus.AA      = src_a_q;
    assign bus.BA      = src_b_q;
    assign bus.DA      = dst_q;
    assign bus.D       = result;
    assign bus.flags   = flags_q;
    assign bus.done    = (state == WB);
    assign bus.illegal = (state == WB) && bad;
    assign bus.write   = (state == WB) && (op_q != OP_CMP) && (op_q != OP_NOP) && !bad;

    // One adder serves ADD/SUB/CMP/INC/DEC; shifts carry an extra bit to expose the last bit out.
    always_comb begin
        y   = (op_q == OP_ADD) ? bus.B : (op_q == OP_INC) ? '0 :
              (op_q == OP_DEC) ? {{(WIDTH-1){1'b1}}, 1'b0} : ~bus.B;
        cin = (op_q != OP_ADD);
        sum = {1'b0, bus.A} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        shl = {1'b0, bus.A} << bus.B[3:0];
        shr = {bus.A, 1'b0} >> bus.B[3:0];
        sra = $signed({bus.A, 1'b0}) >>> bus.B[3:0];
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        upd = 1'b1;
        case (op_q)
            OP_ADD, OP_SUB, OP_CMP, OP_INC, OP_DEC: begin
                r = sum[WIDTH-1:0];
                c = sum[WIDTH];
                v = (bus.A[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_AND:  r = bus.A & bus.B;
            OP_OR:   r = bus.A | bus.B;
            OP_XOR:  r = bus.A ^ bus.B;
            OP_NOT:  r = ~bus.A;
            OP_MOV:  r = bus.A;
            OP_LDI:  r = imm_q;
            OP_SHL:  {c, r} = shl;
            OP_SHR:  {r, c} = shr;
            OP_SRA:  {r, c} = sra;
            default: upd = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= '0;
            dst_q   <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            imm_q   <= '0;
            result  <= '0;
            flags_q <= '0;
`ifdef ALU_MUL_EN
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.in_valid && ready) begin
                    op_q    <= bus.op;
                    dst_q   <= bus.dst;
                    src_a_q <= bus.src_a;
                    src_b_q <= bus.src_b;
                    imm_q   <= bus.imm;
                    state   <= READ;
                end
                READ: begin
`ifdef ALU_MUL_EN
                    cnt   <= '0;
                    state <= (op_q == OP_MUL) ? MUL : EXEC;
`else
                    state <= EXEC;
`endif
                end
                EXEC: begin
                    result <= r;
                    if (upd) flags_q <= {r == '0, r[WIDTH-1], c, v};
                    state <= WB;
                end
`ifdef ALU_MUL_EN
                // First MUL cycle latches the operands the register file just delivered.
                MUL: if (cnt == '0) begin
                    mcand  <= bus.A;
                    mplier <= bus.B;
                    acc    <= '0;
                    cnt    <= CW'(1);
                end else begin
                    acc    <= acc_n;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(MUL_CYCLES)) begin
                        result  <= acc_n;
                        flags_q <= {acc_n == '0, acc_n[WIDTH-1], 2'b00};
                        state   <= WB;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_16.sv
// tb_alu_exec_16: directed bench for alu_exec_16 with a register-file model and a per-cycle reference check
module tb_alu_exec_16;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int          total = 0;
    int          bad = 0;
    logic [15:0] rf  [16];
    logic [15:0] mrf [16];
    int          busy = 0;
    logic [3:0]  mflags = '0;
    logic [3:0]  nflags = '0;
    logic        ew = 1'b0;
    logic        eill = 1'b0;
    logic [3:0]  ed = '0, es1 = '0, es2 = '0;
    logic [15:0] er = '0;

    alu_exec_16_if bus ();
    alu_exec_16 dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    // Registered-read register file the stage talks to.
    always @(posedge clock) begin
        bus.A <= rf[bus.AA];
        bus.B <= rf[bus.BA];
        if (bus.write) rf[bus.DA] <= bus.D;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model(input logic [3:0] o, input logic [15:0] a, b, im, input logic [3:0] fl,
                                  output logic w, output logic il, output logic [15:0] res, output logic [3:0] nf);
        int ua, ub, sa, sb, n;
        logic c, v, u;
        ua = int'(a); ub = int'(b); sa = int'($signed(a)); sb = int'($signed(b)); n = int'(b[3:0]);
        w = 1'b1; il = 1'b0; u = 1'b1; c = 1'b0; v = 1'b0; res = '0;
        case (o)
            4'h0: begin res = 16'(ua + ub); c = (ua + ub) > 65535; v = (sa + sb > 32767) || (sa + sb < -32768); end
            4'h1, 4'hE: begin
                res = 16'(ua - ub); c = ua >= ub; v = (sa - sb > 32767) || (sa - sb < -32768);
                w = (o == 4'h1);
            end
            4'h2: res = a & b;
            4'h3: res = a | b;
            4'h4: res = a ^ b;
            4'h5: res = ~a;
            4'h6: res = a;
            4'h7: begin res = 16'(ua << n); c = (n > 0) && (((ua >> (16 - n)) & 1) != 0); end
            4'h8: begin res = 16'(ua >> n); c = (n > 0) && (((ua >> (n - 1)) & 1) != 0); end
            4'h9: begin res = 16'(sa >>> n); c = (n > 0) && (((ua >> (n - 1)) & 1) != 0); end
            4'hA: res = im;
            4'hB: begin res = 16'(ua + 1); c = (ua == 65535); v = (sa == 32767); end
            4'hC: begin res = 16'(ua - 1); c = (ua != 0); v = (sa == -32768); end
`ifdef ALU_MUL_EN
            4'hD: res = 16'(longint'(ua) * longint'(ub));
`else
            4'hD: begin w = 1'b0; il = 1'b1; u = 1'b0; end
`endif
            default: begin w = 1'b0; u = 1'b0; end
        endcase
        nf = u ? {res == 16'h0, res[15], c, v} : fl;
    endfunction

    // Reference timeline: busy counts the cycles an accepted instruction keeps the stage occupied.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            busy = 0;
            mflags = '0;
        end else if (busy == 0) begin
            if (bus.in_valid) begin
                model(bus.op, mrf[bus.src_a], mrf[bus.src_b], bus.imm, mflags, ew, eill, er, nflags);
                ed = bus.dst; es1 = bus.src_a; es2 = bus.src_b;
`ifdef ALU_MUL_EN
                busy = (bus.op == 4'hD) ? 19 : 3;
`else
                busy = 3;
`endif
            end
        end else begin
            busy--;
            if (busy == 1) mflags = nflags;
            if (busy == 0 && ew) mrf[ed] = er;
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            chk("reset_outs", {bus.in_ready, bus.write, bus.done, bus.illegal, bus.flags, bus.AA, bus.BA, bus.DA, bus.D},
                {1'b1, 35'd0});
        end else begin
            chk("cycle", {bus.in_ready, bus.write, bus.done, bus.illegal, bus.flags},
                {busy == 0, busy == 1 && ew, busy == 1, busy == 1 && eill, mflags});
            if (busy == 1 && ew) chk("wb_bus", {bus.DA, bus.D}, {ed, er});
            if (busy != 0) chk("rd_addr", {bus.AA, bus.BA}, {es1, es2});
        end
    end

    task automatic issue(input logic [3:0] o, d, s1, s2, input logic [15:0] im,
                         output logic w, output logic [3:0] da, output logic [15:0] dd,
                         output logic [3:0] fl, output logic il, output int lat, output int low);
        bit got;
        got = 0; lat = -1; low = 0; w = 0; da = '0; dd = '0; fl = '0; il = 0;
        @(negedge clock);
        bus.in_valid = 1'b1; bus.op = o; bus.dst = d; bus.src_a = s1; bus.src_b = s2; bus.imm = im;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clock);
            bus.in_valid = 1'b0;
            low += int'(!bus.in_ready);
            if (bus.done) begin
                got = 1; lat = k; w = bus.write; da = bus.DA; dd = bus.D; fl = bus.flags; il = bus.illegal;
            end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL timeout: op %h never retired within 40 cycles", o);
        end
    endtask

    task automatic run(input string name, input logic [3:0] o, d, s1, s2, input logic [15:0] im,
                       input logic xw, input logic [15:0] xd, input logic [3:0] xf, input logic xil, input int xlat);
        logic w, il;
        logic [3:0] da, fl;
        logic [15:0] dd;
        int lat, low;
        issue(o, d, s1, s2, im, w, da, dd, fl, il, lat, low);
        chk(name, {w, fl, il}, {xw, xf, xil});
        if (xw) chk({name, "_d"}, {da, dd}, {d, xd});
        chk({name, "_lat"}, {32'(lat), 32'(low)}, {32'(xlat), 32'(xlat + 1)});
    endtask

    initial begin
        logic w, il;
        logic [3:0] da, fl;
        logic [15:0] dd;
        int lat, low;
        for (int i = 0; i < 16; i++) begin rf[i] = '0; mrf[i] = '0; end
        bus.in_valid = 1'b0; bus.op = '0; bus.dst = '0; bus.src_a = '0; bus.src_b = '0; bus.imm = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("reset_idle", {bus.in_ready, bus.write, bus.done, bus.flags}, {1'b1, 1'b0, 1'b0, 4'd0});
        run("ldi_r1",  4'hA, 4'd1, 4'd0, 4'd0, 16'h0005, 1'b1, 16'h0005, 4'b0000, 1'b0, 2);
        run("ldi_r2",  4'hA, 4'd2, 4'd0, 4'd0, 16'h0003, 1'b1, 16'h0003, 4'b0000, 1'b0, 2);
        run("add",     4'h0, 4'd3, 4'd1, 4'd2, 16'h0,    1'b1, 16'h0008, 4'b0000, 1'b0, 2);
        run("sub",     4'h1, 4'd4, 4'd2, 4'd1, 16'h0,    1'b1, 16'hFFFE, 4'b0100, 1'b0, 2);
        run("ldi_r6",  4'hA, 4'd6, 4'd0, 4'd0, 16'h7FFF, 1'b1, 16'h7FFF, 4'b0000, 1'b0, 2);
        run("ldi_r7",  4'hA, 4'd7, 4'd0, 4'd0, 16'h0001, 1'b1, 16'h0001, 4'b0000, 1'b0, 2);
        run("add_ovf", 4'h0, 4'd8, 4'd6, 4'd7, 16'h0,    1'b1, 16'h8000, 4'b0101, 1'b0, 2);
        run("cmp",     4'hE, 4'd0, 4'd8, 4'd8, 16'h0,    1'b0, 16'h0000, 4'b1010, 1'b0, 2);
`ifdef ALU_MUL_EN
        run("mul",     4'hD, 4'd5, 4'd1, 4'd2, 16'h0,    1'b1, 16'h000F, 4'b0000, 1'b0, 18);
`else
        run("mul_off", 4'hD, 4'd5, 4'd1, 4'd2, 16'h0,    1'b0, 16'h0000, 4'b1010, 1'b1, 2);
`endif
        // Abort an instruction in flight with an asynchronous reset.
        @(negedge clock);
        bus.in_valid = 1'b1; bus.dst = 4'd5; bus.src_a = 4'd1; bus.src_b = 4'd2;
`ifdef ALU_MUL_EN
        bus.op = 4'hD;
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        repeat (10) @(posedge clock);
`else
        bus.op = 4'h0;
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        @(posedge clock);
`endif
        #2 reset = 1'b1;
        #1 chk("abort", {bus.write, bus.in_ready, bus.done, bus.flags, bus.DA, bus.D},
               {1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 16'd0});
        repeat (2) @(negedge clock);
        reset = 1'b0;
        run("ldi_r9",  4'hA, 4'd9,  4'd0,  4'd0,  16'h1234, 1'b1, 16'h1234, 4'b0000, 1'b0, 2);
        run("ldi_r1b", 4'hA, 4'd1,  4'd0,  4'd0,  16'h8005, 1'b1, 16'h8005, 4'b0100, 1'b0, 2);
        run("ldi_r10", 4'hA, 4'd10, 4'd0,  4'd0,  16'h0003, 1'b1, 16'h0003, 4'b0000, 1'b0, 2);
        run("shl",     4'h7, 4'd11, 4'd1,  4'd10, 16'h0,    1'b1, 16'h0028, 4'b0000, 1'b0, 2);
        run("shr",     4'h8, 4'd15, 4'd1,  4'd10, 16'h0,    1'b1, 16'h1000, 4'b0010, 1'b0, 2);
        run("ldi_r12", 4'hA, 4'd12, 4'd0,  4'd0,  16'h8000, 1'b1, 16'h8000, 4'b0100, 1'b0, 2);
        run("ldi_r13", 4'hA, 4'd13, 4'd0,  4'd0,  16'h0004, 1'b1, 16'h0004, 4'b0000, 1'b0, 2);
        run("sra",     4'h9, 4'd14, 4'd12, 4'd13, 16'h0,    1'b1, 16'hF800, 4'b0100, 1'b0, 2);
        run("inc_ovf", 4'hB, 4'd15, 4'd6,  4'd0,  16'h0,    1'b1, 16'h8000, 4'b0101, 1'b0, 2);
        run("dec_brw", 4'hC, 4'd15, 4'd0,  4'd0,  16'h0,    1'b1, 16'hFFFF, 4'b0100, 1'b0, 2);
        run("nop",     4'hF, 4'd15, 4'd0,  4'd0,  16'h0,    1'b0, 16'h0000, 4'b0100, 1'b0, 2);
        run("shl0",    4'h7, 4'd15, 4'd1,  4'd0,  16'h0,    1'b1, 16'h8005, 4'b0100, 1'b0, 2);
        for (int i = 0; i < 5; i++)
            issue(4'(2 + i), 4'(3 + i), 4'd1, 4'd12, 16'h0, w, da, dd, fl, il, lat, low);
        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: summary not reached");
        $fatal(1);
    end
endmodule
